des_stream_ctrl: RTL and testbench
==================================

// Module: des_stream_ctrl
// PURPOSE
//  Parametrised block sequencer between the I2C slave, block SRAM and the triple-DES core.
//  - On an I2C write transaction it streams blk_count 64-bit blocks: read SRAM, run the core, write the result back.
//  - Generalises the single-block main-controller/addr-gen pair: configurable address space, block count, 2- or 3-key keying and abort.
//  - Also drives key and mode to the core and supports optional CBC chaining.
// PARAMETERS
//  ADDR_W      16       SRAM address width; all address arithmetic is modulo 2**ADDR_W
//  MAX_BLOCKS  16       max blocks per job; CNT_W = $clog2(MAX_BLOCKS+1)
//  NUM_KEYS    3        2 or 3; when 2, des_key3 = key slot 0 (EDE2)
//  RD_BASE     'h0000   ADDR_W-bit byte address of source block 0
//  WR_BASE     'h0100   ADDR_W-bit byte address of result block 0
// PORTS
//  clk         in   1      system clock, rising edge
//  n_rst       in   1      asynchronous active-low reset
//  i2c_stop    in   1      1-cycle pulse at end of I2C transaction
//  i2c_rw      in   1      transaction dir at stop; 0 = host write -> start job
//  decrypt     in   1      job mode, sampled at start; 0 = encrypt
//  blk_count   in   CNT_W  blocks in job, sampled at start; values > MAX_BLOCKS clamp to MAX_BLOCKS
//  abort       in   1      synchronous job cancel
//  key_wr      in   1      write key_in into slot key_sel
//  key_sel     in   2      0..2 key slots, 3 = IV (CBC only)
//  key_in      in   64     key/IV data
//  address     out  ADDR_W SRAM byte address
//  read_en     out  1      SRAM read strobe; rdata valid next cycle
//  write_en    out  1      SRAM write strobe
//  mem_rdata   in   64     SRAM read data
//  mem_wdata   out  64     SRAM write data
//  des_key1/2/3 out 64     core keys
//  des_decrypt out  1      core mode
//  des_in      out  64     core input block, stable from des_start to des_done
//  des_start   out  1      1-cycle core launch
//  des_done    in   1      1-cycle core completion; des_out valid that cycle
//  des_out     in   64     core result
//  busy        out  1      high in every state except IDLE
//  done        out  1      1-cycle job-complete pulse
//  err         out  1      1-cycle pulse on abort
// BEHAVIOUR
//  Reset values: all outputs, key slots, IV and counters are 0; state is IDLE.
//  States and transitions:
//  - IDLE: start = i2c_stop & ~i2c_rw. On start, latch mode/count and set idx=0.
//    Next state is DONE if count==0, else RD_REQ.
//  - RD_REQ: read_en=1, address = RD_BASE + idx*8. Next: RD_WAIT.
//  - RD_WAIT: capture mem_rdata into blk_q. Next: START.
//  - START: des_start=1. Next: CORE_WAIT.
//  - CORE_WAIT: hold until des_done, then capture des_out into res_q. Next: WR.
//  - WR: write_en=1, address = WR_BASE + idx*8, mem_wdata = res_q.
//    Next: DONE if idx==count-1, else idx++ and RD_REQ.
//  - DONE: done=1. Next: IDLE.
//  Latency: L = cycles from des_start to des_done (L>=1). Each block takes 4+L cycles. done is high N*(4+L)+1 cycles after the start cycle.
//  Boundaries and events:
//  - i2c_stop while busy is ignored.
//  - des_done outside CORE_WAIT is ignored.
//  - Address arithmetic wraps modulo 2**ADDR_W.
//  - abort in any non-IDLE state: next state IDLE, err pulses, no done, no further read/write. If abort coincides with WR, that write is suppressed. abort has priority over des_done.
//  - key_wr while busy is ignored. Slot 2 writes are ignored when NUM_KEYS==2.
//  - Asynchronous reset mid-job returns to IDLE immediately; all strobes drop.
// CONFIGURATION
//  DES_CBC_EN defined: CBC mode. key_sel==3 loads the IV. chain = IV at job start.
//  - Encrypt: des_in = blk_q ^ chain; chain = des_out.
//  - Decrypt: des_in = blk_q; res = des_out ^ chain; chain = blk_q.
//  DES_CBC_EN undefined: ECB. des_in = blk_q. key_sel==3 writes are ignored. No IV or chain registers exist.
// STRUCTURE
//  Package des_stream_pkg:
//  - state_t enum (IDLE..DONE)
//  - BLOCK_W=64, KEY_W=64, BYTES_PER_BLK=8
//  - key_slot_t enum (K1,K2,K3,IV)
//  Sub-module des_key_bank: slot registers, busy lock, NUM_KEYS mapping, IV register under DES_CBC_EN.
// TESTING
//  - Reset: assert n_rst low mid-job -> all outputs 0 and busy 0 within the same cycle.
//  - 3-block ECB, core model L=5: reads at 0000/0008/0010, writes at 0100/0108/0110; done at cycle 28.
//  - blk_count=0: start -> done one cycle later; no read_en or write_en.
//  - abort during block 2 CORE_WAIT -> err pulse, no write to 0108, IDLE; key_wr while busy leaves keys unchanged.
//  - RD_BASE='hFFF8, 2 blocks -> reads at FFF8 then 0000.
//  - DES_CBC_EN, identity core, IV=A5A5..., encrypt P0,P1 -> writes P0^IV, P1^P0^IV; decrypt restores P0,P1.

Source files
------------

// File: rtl/des_stream_pkg.sv
// Shared types and constants for the triple-DES block stream controller.
package des_stream_pkg;

   localparam int BLOCK_W       = 64;
   localparam int KEY_W         = 64;
   localparam int BYTES_PER_BLK = 8;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      START,
      CORE_WAIT,
      WR,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      K1,
      K2,
      K3,
      IV
   } key_slot_t;

endpackage

// File: rtl/des_key_bank.sv
// Key slot registers for the DES core; writes are locked out while a job runs.
// The IV register exists only when DES_CBC_EN is defined.
module des_key_bank
   import des_stream_pkg::*;
#(
   parameter int NUM_KEYS = 3
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             busy,
   input  logic             key_wr,
   input  logic [1:0]       key_sel,
   input  logic [KEY_W-1:0] key_in,
   output logic [KEY_W-1:0] key1,
   output logic [KEY_W-1:0] key2,
   output logic [KEY_W-1:0] key3
`ifdef DES_CBC_EN
   ,
   output logic [KEY_W-1:0] iv
`endif
);

   logic [KEY_W-1:0] k1_q, k2_q, k3_q;
`ifdef DES_CBC_EN
   logic [KEY_W-1:0] iv_q;
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         k1_q <= '0;
         k2_q <= '0;
         k3_q <= '0;
`ifdef DES_CBC_EN
         iv_q <= '0;
`endif
      end else if (key_wr && !busy) begin
         case (key_slot_t'(key_sel))
            K1: k1_q <= key_in;
            K2: k2_q <= key_in;
            K3: if (NUM_KEYS == 3) k3_q <= key_in;
            IV: begin
`ifdef DES_CBC_EN
               iv_q <= key_in;
`endif
            end
            default: ;
         endcase
      end
   end

   // Two-key EDE reuses the first key for the final stage.
   assign key1 = k1_q;
   assign key2 = k2_q;
   assign key3 = (NUM_KEYS == 2) ? k1_q : k3_q;
`ifdef DES_CBC_EN
   assign iv   = iv_q;
`endif

endmodule

// File: rtl/des_stream_ctrl.sv
// Streams blk_count 64-bit blocks SRAM -> triple-DES core -> SRAM after an I2C write.
// Define DES_CBC_EN to build the CBC chaining variant; otherwise blocks are processed ECB.
module des_stream_ctrl
   import des_stream_pkg::*;
#(
   parameter int              ADDR_W     = 16,
   parameter int              MAX_BLOCKS = 16,
   parameter int              NUM_KEYS   = 3,
   parameter logic [ADDR_W-1:0] RD_BASE  = ADDR_W'('h0000),
   parameter logic [ADDR_W-1:0] WR_BASE  = ADDR_W'('h0100),
   localparam int             CNT_W      = $clog2(MAX_BLOCKS + 1)
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               i2c_stop,
   input  logic               i2c_rw,
   input  logic               decrypt,
   input  logic [CNT_W-1:0]   blk_count,
   input  logic               abort,
   input  logic               key_wr,
   input  logic [1:0]         key_sel,
   input  logic [KEY_W-1:0]   key_in,
   output logic [ADDR_W-1:0]  address,
   output logic               read_en,
   output logic               write_en,
   input  logic [BLOCK_W-1:0] mem_rdata,
   output logic [BLOCK_W-1:0] mem_wdata,
   output logic [KEY_W-1:0]   des_key1,
   output logic [KEY_W-1:0]   des_key2,
   output logic [KEY_W-1:0]   des_key3,
   output logic               des_decrypt,
   output logic [BLOCK_W-1:0] des_in,
   output logic               des_start,
   input  logic               des_done,
   input  logic [BLOCK_W-1:0] des_out,
   output logic               busy,
   output logic               done,
   output logic               err
);

   function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] n);
      if (n > CNT_W'(MAX_BLOCKS)) return CNT_W'(MAX_BLOCKS);
      return n;
   endfunction

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    idx_q, cnt_q;
   logic                mode_q;
   logic [BLOCK_W-1:0]  blk_q, res_q;
   logic [ADDR_W-1:0]   blk_off;
   logic                start, last, busy_int;
`ifdef DES_CBC_EN
   logic [KEY_W-1:0]    iv;
   logic [BLOCK_W-1:0]  chain_q;
`endif

   assign start    = i2c_stop & ~i2c_rw;
   assign last     = (idx_q == cnt_q - CNT_W'(1));
   assign busy_int = (state_q != IDLE);
   assign blk_off  = ADDR_W'(idx_q) * ADDR_W'(BYTES_PER_BLK);

   des_key_bank #(
      .NUM_KEYS(NUM_KEYS)
   ) u_key_bank (
      .clk    (clk),
      .n_rst  (n_rst),
      .busy   (busy_int),
      .key_wr (key_wr),
      .key_sel(key_sel),
      .key_in (key_in),
      .key1   (des_key1),
      .key2   (des_key2),
      .key3   (des_key3)
`ifdef DES_CBC_EN
      ,
      .iv     (iv)
`endif
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Abort wins over every other transition, including a coincident des_done.
   always_comb begin
      state_d = state_q;
      if (abort && busy_int) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:      if (start) state_d = (clamp_count(blk_count) == '0) ? DONE : RD_REQ;
            RD_REQ:    state_d = RD_WAIT;
            RD_WAIT:   state_d = START;
            START:     state_d = CORE_WAIT;
            CORE_WAIT: if (des_done) state_d = WR;
            WR:        state_d = last ? DONE : RD_REQ;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      read_en   = 1'b0;
      write_en  = 1'b0;
      des_start = 1'b0;
      done      = 1'b0;
      address   = '0;
      busy      = busy_int;
      err       = abort && busy_int;
      case (state_q)
         RD_REQ: begin
            read_en = !abort;
            address = RD_BASE + blk_off;
         end
         START:  des_start = !abort;
         WR: begin
            write_en = !abort;
            address  = WR_BASE + blk_off;
         end
         DONE:   done = !abort;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         idx_q   <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         blk_q   <= '0;
         res_q   <= '0;
`ifdef DES_CBC_EN
         chain_q <= '0;
`endif
      end else begin
         if (state_q == IDLE && start) begin
            idx_q   <= '0;
            cnt_q   <= clamp_count(blk_count);
            mode_q  <= decrypt;
`ifdef DES_CBC_EN
            chain_q <= iv;
`endif
         end
         if (state_q == RD_WAIT && !abort) blk_q <= mem_rdata;
         if (state_q == CORE_WAIT && des_done && !abort) begin
`ifdef DES_CBC_EN
            if (mode_q) begin
               res_q   <= des_out ^ chain_q;
               chain_q <= blk_q;
            end else begin
               res_q   <= des_out;
               chain_q <= des_out;
            end
`else
            res_q <= des_out;
`endif
         end
         if (state_q == WR && !abort && !last) idx_q <= idx_q + CNT_W'(1);
      end
   end

   assign mem_wdata   = res_q;
   assign des_decrypt = mode_q;
`ifdef DES_CBC_EN
   assign des_in      = mode_q ? blk_q : (blk_q ^ chain_q);
`else
   assign des_in      = blk_q;
`endif

endmodule

// File: tb/tb_des_stream_ctrl.sv
// Directed bench for des_stream_ctrl with a 5-cycle-latency core model and a small SRAM model.
module tb_des_stream_ctrl;

   localparam int CNT_W = 5;

   logic        clk = 1'b0;
   logic        n_rst = 1'b1;
   logic        i2c_stop = 1'b0, i2c_rw = 1'b0, decrypt = 1'b0, abort = 1'b0;
   logic [CNT_W-1:0] blk_count = '0;
   logic        key_wr = 1'b0;
   logic [1:0]  key_sel = '0;
   logic [63:0] key_in = '0;

   logic [15:0] address, address2;
   logic        read_en, write_en, read_en2, write_en2;
   logic [63:0] mem_rdata = '0, mem_rdata2 = '0, mem_wdata, mem_wdata2;
   logic [63:0] des_key1, des_key2, des_key3, k1_2, k2_2, k3_2;
   logic        des_decrypt, des_decrypt2;
   logic [63:0] des_in, des_in2;
   logic        des_start, des_start2;
   logic        des_done = 1'b0, des_done2 = 1'b0;
   logic [63:0] des_out = '0, des_out2 = '0;
   logic        busy, busy2, done, done2, err, err2;

   int          n_checks = 0, n_bad = 0;
   int          cyc = 0;
   int          ccnt = 0, ccnt2 = 0;
   bit          core_id = 1'b0;
   logic [63:0] src_tab [0:7];
   logic [15:0] rd_q[$], wa_q[$], rd2_q[$];
   logic [63:0] wd_q[$];
   int          st_cnt = 0, done_cnt = 0;

   des_stream_ctrl dut (
      .clk(clk), .n_rst(n_rst), .i2c_stop(i2c_stop), .i2c_rw(i2c_rw), .decrypt(decrypt),
      .blk_count(blk_count), .abort(abort), .key_wr(key_wr), .key_sel(key_sel), .key_in(key_in),
      .address(address), .read_en(read_en), .write_en(write_en), .mem_rdata(mem_rdata),
      .mem_wdata(mem_wdata), .des_key1(des_key1), .des_key2(des_key2), .des_key3(des_key3),
      .des_decrypt(des_decrypt), .des_in(des_in), .des_start(des_start), .des_done(des_done),
      .des_out(des_out), .busy(busy), .done(done), .err(err)
   );

   des_stream_ctrl #(.NUM_KEYS(2), .RD_BASE(16'hFFF8)) dut2 (
      .clk(clk), .n_rst(n_rst), .i2c_stop(i2c_stop), .i2c_rw(i2c_rw), .decrypt(decrypt),
      .blk_count(blk_count), .abort(abort), .key_wr(key_wr), .key_sel(key_sel), .key_in(key_in),
      .address(address2), .read_en(read_en2), .write_en(write_en2), .mem_rdata(mem_rdata2),
      .mem_wdata(mem_wdata2), .des_key1(k1_2), .des_key2(k2_2), .des_key3(k3_2),
      .des_decrypt(des_decrypt2), .des_in(des_in2), .des_start(des_start2), .des_done(des_done2),
      .des_out(des_out2), .busy(busy2), .done(done2), .err(err2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // SRAM: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (read_en)  mem_rdata  <= src_tab[address[5:3]];
      if (read_en2) mem_rdata2 <= src_tab[address2[5:3]];
   end

   // Core: des_done arrives 5 cycles after des_start; ~x by default, identity for CBC.
   always @(posedge clk) begin
      des_done  <= 1'b0;
      des_done2 <= 1'b0;
      if (des_start) ccnt <= 4;
      else if (ccnt != 0) begin
         ccnt <= ccnt - 1;
         if (ccnt == 1) begin
            des_done <= 1'b1;
            des_out  <= core_id ? des_in : ~des_in;
         end
      end
      if (des_start2) ccnt2 <= 4;
      else if (ccnt2 != 0) begin
         ccnt2 <= ccnt2 - 1;
         if (ccnt2 == 1) begin
            des_done2 <= 1'b1;
            des_out2  <= core_id ? des_in2 : ~des_in2;
         end
      end
   end

   always @(negedge clk) begin
      if (read_en)  rd_q.push_back(address);
      if (read_en2) rd2_q.push_back(address2);
      if (write_en) begin
         wa_q.push_back(address);
         wd_q.push_back(mem_wdata);
      end
      if (des_start) st_cnt++;
      if (done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      rd_q.delete();
      rd2_q.delete();
      wa_q.delete();
      wd_q.delete();
   endtask

   task automatic set_key(input logic [1:0] sel, input logic [63:0] val);
      @(negedge clk);
      key_sel = sel;
      key_in  = val;
      key_wr  = 1'b1;
      @(negedge clk);
      key_wr  = 1'b0;
   endtask

   task automatic start_job(input logic [CNT_W-1:0] n, input logic dec, output int c0);
      @(negedge clk);
      blk_count = n;
      decrypt   = dec;
      i2c_rw    = 1'b0;
      i2c_stop  = 1'b1;
      c0        = cyc;
      @(negedge clk);
      i2c_stop  = 1'b0;
   endtask

   task automatic wait_done(output int dc, output bit seen);
      seen = 1'b0;
      dc   = 0;
      for (int i = 0; i < 400; i++) begin
         if (done) begin
            dc   = cyc;
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int  c0, dc, base_st, base_done;
      bit  seen;

      for (int i = 0; i < 8; i++) src_tab[i] = 64'hC0DE_0000_0000_0000 | 64'(i * 8);

      #2 n_rst = 1'b0;
      #1;
      chk("rst_ctrl", 64'({busy, read_en, write_en, des_start, done, err, des_decrypt}), 64'h0);
      chk("rst_addr", 64'(address), 64'h0);
      chk("rst_data", mem_wdata | des_in | des_key1 | des_key2 | des_key3, 64'h0);
      @(negedge clk);
      @(negedge clk);
      n_rst = 1'b1;

      set_key(2'd0, 64'h1111_1111_1111_1111);
      set_key(2'd1, 64'h2222_2222_2222_2222);
      set_key(2'd2, 64'h3333_3333_3333_3333);
      @(negedge clk);
      chk("key1", des_key1, 64'h1111_1111_1111_1111);
      chk("key2", des_key2, 64'h2222_2222_2222_2222);
      chk("key3", des_key3, 64'h3333_3333_3333_3333);
      chk("ede2_key3", k3_2, 64'h1111_1111_1111_1111);

      // Three-block ECB job
      clear_logs();
      start_job(5'd3, 1'b0, c0);
      chk("ecb_busy", 64'(busy), 64'h1);
      wait_done(dc, seen);
      chk("ecb_done_seen", 64'(seen), 64'h1);
      chk("ecb_done_cyc", 64'(dc - c0), 64'd28);
      @(negedge clk);
      chk("ecb_idle", 64'(busy), 64'h0);
      chk("ecb_nrd", 64'(rd_q.size()), 64'd3);
      chk("ecb_rd0", 64'(rd_q[0]), 64'h0000);
      chk("ecb_rd1", 64'(rd_q[1]), 64'h0008);
      chk("ecb_rd2", 64'(rd_q[2]), 64'h0010);
      chk("ecb_nwr", 64'(wa_q.size()), 64'd3);
      chk("ecb_wa0", 64'(wa_q[0]), 64'h0100);
      chk("ecb_wa1", 64'(wa_q[1]), 64'h0108);
      chk("ecb_wa2", 64'(wa_q[2]), 64'h0110);
`ifndef DES_CBC_EN
      chk("ecb_wd0", wd_q[0], 64'h3F21_FFFF_FFFF_FFFF);
      chk("ecb_wd1", wd_q[1], 64'h3F21_FFFF_FFFF_FFF7);
      chk("ecb_wd2", wd_q[2], 64'h3F21_FFFF_FFFF_FFEF);
`endif

      // Zero-block job
      clear_logs();
      start_job(5'd0, 1'b0, c0);
      wait_done(dc, seen);
      chk("zero_done_cyc", 64'(dc - c0), 64'd1);
      repeat (3) @(negedge clk);
      chk("zero_noacc", 64'(rd_q.size() + wa_q.size()), 64'd0);

      // Abort in block 2 CORE_WAIT, with a key write attempted while busy
      clear_logs();
      base_st   = st_cnt;
      base_done = done_cnt;
      start_job(5'd3, 1'b1, c0);
      chk("abort_mode", 64'(des_decrypt), 64'h1);
      set_key(2'd0, 64'hDEAD_BEEF_DEAD_BEEF);
      chk("busy_keylock", des_key1, 64'h1111_1111_1111_1111);
      for (int i = 0; i < 200; i++) begin
         if (st_cnt >= base_st + 2) break;
         @(negedge clk);
      end
      chk("abort_reach_blk2", 64'(st_cnt - base_st), 64'd2);
      @(negedge clk);
      abort = 1'b1;
      #1;
      chk("abort_err", 64'(err), 64'h1);
      @(negedge clk);
      abort = 1'b0;
      chk("abort_idle", 64'({busy, err}), 64'h0);
      repeat (15) @(negedge clk);
      chk("abort_nwr", 64'(wa_q.size()), 64'd1);
      chk("abort_wa0", 64'(wa_q[0]), 64'h0100);
      chk("abort_nodone", 64'(done_cnt - base_done), 64'd0);

      // Read address wraps past the top of the address space
      clear_logs();
      start_job(5'd2, 1'b0, c0);
      wait_done(dc, seen);
      repeat (2) @(negedge clk);
      chk("wrap_nrd", 64'(rd2_q.size()), 64'd2);
      chk("wrap_rd0", 64'(rd2_q[0]), 64'hFFF8);
      chk("wrap_rd1", 64'(rd2_q[1]), 64'h0000);

      // Oversized count clamps to 16 blocks
      clear_logs();
      start_job(5'd20, 1'b0, c0);
      wait_done(dc, seen);
      chk("clamp_done_cyc", 64'(dc - c0), 64'd145);
      @(negedge clk);
      chk("clamp_nwr", 64'(wa_q.size()), 64'd16);
      chk("clamp_walast", 64'(wa_q[15]), 64'h0178);

      // Asynchronous reset while a read is in flight
      clear_logs();
      start_job(5'd3, 1'b0, c0);
      chk("pre_rst_rd", 64'(read_en), 64'h1);
      n_rst = 1'b0;
      #1;
      chk("mid_rst_ctrl", 64'({busy, read_en, write_en, des_start, done, err}), 64'h0);
      chk("mid_rst_addr", 64'(address), 64'h0);
      chk("mid_rst_key", des_key1, 64'h0);
      @(negedge clk);
      n_rst = 1'b1;
      repeat (8) @(negedge clk);

`ifdef DES_CBC_EN
      core_id = 1'b1;
      set_key(2'd3, 64'hA5A5_A5A5_A5A5_A5A5);
      clear_logs();
      start_job(5'd2, 1'b0, c0);
      wait_done(dc, seen);
      @(negedge clk);
      chk("cbc_enc0", wd_q[0], 64'h657B_A5A5_A5A5_A5A5);
      chk("cbc_enc1", wd_q[1], 64'hA5A5_A5A5_A5A5_A5AD);
      src_tab[0] = 64'h657B_A5A5_A5A5_A5A5;
      src_tab[1] = 64'hA5A5_A5A5_A5A5_A5AD;
      clear_logs();
      start_job(5'd2, 1'b1, c0);
      wait_done(dc, seen);
      @(negedge clk);
      chk("cbc_dec0", wd_q[0], 64'hC0DE_0000_0000_0000);
      chk("cbc_dec1", wd_q[1], 64'hC0DE_0000_0000_0008);
`endif

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
